// File: rtl/sw_pkg.sv
// Shared types and default sizing for the switch debounce/event block.
package sw_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } sw_evt_state_t;

   localparam int unsigned SW_WIDTH         = 8;
   localparam int unsigned SW_STABLE_CYCLES = 16;

endpackage : sw_pkg

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a stability counter.
// lvl_o is the debounced level; tgl_o is high during the cycle whose
// closing edge flips lvl_o, so the parent can act on that same edge.
module sw_debounce_bit
   import sw_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = SW_STABLE_CYCLES,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_i,
   output logic lvl_o,
   output logic tgl_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             lvl_q, lvl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flip;

   // Counter runs only while the synchronised input disagrees with the level.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      flip  = 1'b0;
      if (s2_q != lvl_q) begin
         if (cnt_q == CNT_LAST) begin
            flip  = 1'b1;
            lvl_d = ~lvl_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchroniser, counter and debounced level registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         lvl_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= sw_i;
         s2_q  <= s1_q;
         lvl_q <= lvl_d;
         cnt_q <= cnt_d;
      end
   end

   assign lvl_o = lvl_q;
   assign tgl_o = flip;

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// Debounces a switch bus and reports each debounced change as a
// valid/ready event carrying a level snapshot and a toggle mask.
module sw_debounce
   import sw_pkg::*;
#(
   parameter int unsigned WIDTH         = SW_WIDTH,
   parameter int unsigned STABLE_CYCLES = SW_STABLE_CYCLES,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] sw_db,
   output logic             chg_valid,
   input  logic             chg_ready,
   output logic [WIDTH-1:0] chg_data,
   output logic [WIDTH-1:0] chg_mask,
   output logic             overrun
);

   logic [WIDTH-1:0] lvl, tgl, avail;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             overrun_q, overrun_d;
   sw_evt_state_t    state_q, state_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W)
      ) u_bit (
         .clk   (clk),
         .rst   (rst),
         .sw_i  (sw[i]),
         .lvl_o (lvl[i]),
         .tgl_o (tgl[i])
      );
   end

   assign avail = pend_q | tgl;

   // Event FSM: captures pending toggles into the snapshot, handles handshake.
   // In IDLE, toggles landing on the capture edge stay pending for the next
   // event; on an OFFER handshake they are folded into the reloaded snapshot.
   always_comb begin
      state_d   = state_q;
      pend_d    = avail;
      data_d    = data_q;
      mask_d    = mask_q;
      overrun_d = overrun_q | (|(pend_q & tgl));
      unique case (state_q)
         IDLE: begin
            if (|pend_q) begin
               state_d = OFFER;
               mask_d  = pend_q;
               data_d  = lvl;
               pend_d  = tgl;
            end
         end
         OFFER: begin
            if (chg_ready) begin
               if (|avail) begin
                  mask_d = avail;
                  data_d = lvl ^ tgl;
                  pend_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pending, snapshot and sticky overrun registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pend_q    <= '0;
         data_q    <= '0;
         mask_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         data_q    <= data_d;
         mask_q    <= mask_d;
         overrun_q <= overrun_d;
      end
   end

   assign sw_db     = lvl;
   assign chg_valid = (state_q == OFFER);
   assign chg_data  = data_q;
   assign chg_mask  = mask_q;
   assign overrun   = overrun_q;

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (WIDTH=8, STABLE_CYCLES=4) with an event
// scoreboard checked by an independent handshake monitor.
module tb_sw_debounce;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] mask;
   } evt_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sw;
   logic [7:0] sw_db;
   logic       chg_valid;
   logic       chg_ready;
   logic [7:0] chg_data;
   logic [7:0] chg_mask;
   logic       overrun;

   int   n_checks = 0;
   int   n_pass   = 0;
   evt_t sb[$];

   sw_debounce #(
      .WIDTH         (8),
      .STABLE_CYCLES (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .sw_db     (sw_db),
      .chg_valid (chg_valid),
      .chg_ready (chg_ready),
      .chg_data  (chg_data),
      .chg_mask  (chg_mask),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic [7:0] m);
      evt_t e;
      e.data = d;
      e.mask = m;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input string name);
      int done;
      done = 0;
      for (int c = 0; c < 40 && done == 0; c++) begin
         tick(1);
         if (sb.size() == 0 && chg_valid == 1'b0) done = 1;
      end
      n_checks++;
      if (done != 0) n_pass++;
      else $display("FAIL %s_drain: timeout, %0d events outstanding, chg_valid=%0b",
                    name, sb.size(), chg_valid);
   endtask

   // Monitor: a transfer happens at the next edge whenever valid && ready.
   always @(negedge clk) begin
      if (rst === 1'b0 && chg_valid === 1'b1 && chg_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got data=0x%0h mask=0x%0h expected none",
                     chg_data, chg_mask);
         end else begin
            evt_t e;
            e = sb.pop_front();
            check("evt_data", 32'(chg_data), 32'(e.data));
            check("evt_mask", 32'(chg_mask), 32'(e.mask));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with all switches high.
      rst = 1'b1; sw = 8'hFF; chg_ready = 1'b0;
      tick(3);
      check("rst_sw_db",   32'(sw_db),     32'h0);
      check("rst_valid",   32'(chg_valid), 32'h0);
      check("rst_data",    32'(chg_data),  32'h0);
      check("rst_mask",    32'(chg_mask),  32'h0);
      check("rst_overrun", 32'(overrun),   32'h0);
      rst = 1'b0;
      push(8'hFF, 8'hFF);
      tick(5);
      check("init_sw_db_early", 32'(sw_db), 32'h00);
      tick(1);
      check("init_sw_db",       32'(sw_db), 32'hFF);
      check("init_valid_early", 32'(chg_valid), 32'h0);
      tick(1);
      check("init_valid", 32'(chg_valid), 32'h1);
      check("init_data",  32'(chg_data),  32'hFF);
      check("init_mask",  32'(chg_mask),  32'hFF);
      chg_ready = 1'b1;
      wait_drain("init");
      sw = 8'h00; push(8'h00, 8'hFF);
      wait_drain("init_clear");

      // Bounce rejection on bit 0.
      sw = 8'h01; push(8'h01, 8'h01);
      tick(3);
      sw = 8'h00;
      tick(1);
      sw = 8'h01;
      tick(5);
      check("bounce_early", 32'(sw_db), 32'h00);
      tick(1);
      check("bounce_rise",  32'(sw_db), 32'h01);
      wait_drain("bounce");
      sw = 8'h00; push(8'h00, 8'h01);
      wait_drain("bounce_clear");

      // Backpressure: bit3 then bit5 ten cycles later.
      chg_ready = 1'b0;
      sw = 8'h08; push(8'h08, 8'h08);
      tick(8);
      check("bp_mask_a", 32'(chg_mask), 32'h08);
      tick(2);
      sw = 8'h28; push(8'h28, 8'h20);
      tick(7);
      check("bp_valid",  32'(chg_valid), 32'h1);
      check("bp_mask_b", 32'(chg_mask),  32'h08);
      check("bp_data_b", 32'(chg_data),  32'h08);
      chg_ready = 1'b1;
      tick(1);
      check("bp_b2b_valid", 32'(chg_valid), 32'h1);
      check("bp_b2b_mask",  32'(chg_mask),  32'h20);
      check("bp_b2b_data",  32'(chg_data),  32'h28);
      tick(1);
      check("bp_idle", 32'(chg_valid), 32'h0);
      wait_drain("bp");
      sw = 8'h00; push(8'h00, 8'h28);
      wait_drain("bp_clear");

      // Simultaneous toggles of bits 0 and 7.
      sw = 8'h81; push(8'h81, 8'h81);
      wait_drain("simul");
      sw = 8'h00; push(8'h00, 8'h81);
      wait_drain("simul_clear");

      // Overrun: bit1 event stalled, then bit2 goes 0->1->0 uncaptured.
      check("ovr_before", 32'(overrun), 32'h0);
      chg_ready = 1'b0;
      sw = 8'h02; push(8'h02, 8'h02);
      tick(8);
      sw = 8'h06;
      tick(8);
      check("ovr_single", 32'(overrun), 32'h0);
      sw = 8'h02; push(8'h02, 8'h04);
      tick(8);
      check("ovr_set", 32'(overrun), 32'h1);
      chg_ready = 1'b1;
      wait_drain("ovr");
      check("ovr_sticky", 32'(overrun), 32'h1);
      sw = 8'h00; push(8'h00, 8'h02);
      wait_drain("ovr_clear");
      check("ovr_sticky2", 32'(overrun), 32'h1);

      // Reset while an event is offered.
      chg_ready = 1'b0;
      sw = 8'h10; push(8'h10, 8'h10);
      tick(7);
      check("mid_valid", 32'(chg_valid), 32'h1);
      rst = 1'b1; sw = 8'h00;
      void'(sb.pop_back());
      tick(1);
      check("mid_rst_valid",   32'(chg_valid), 32'h0);
      check("mid_rst_sw_db",   32'(sw_db),     32'h00);
      check("mid_rst_mask",    32'(chg_mask),  32'h00);
      check("mid_rst_overrun", 32'(overrun),   32'h0);
      rst = 1'b0; chg_ready = 1'b1;
      tick(20);
      check("mid_no_stale", 32'(chg_valid), 32'h0);
      check("mid_sw_db",    32'(sw_db),     32'h00);
      check("sb_empty",     32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_sw_debounce
